// File: rtl/sfm_stream_framer.sv
// Softmax input framer: counts beats of a byte-length vector, tags the last beat,
// pads unused lanes of a partial last beat with -inf and emits lane-valid/strobe flags.
module sfm_stream_framer #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned IN_WIDTH    = 16,  // FP16ALT (bfloat16) element width
  parameter int unsigned IN_EXP_BITS = 8    // FP16ALT exponent width
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      start_i,
  input  logic [31:0]               tot_len_i,
  input  logic [DATA_WIDTH-1:0]     in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [DATA_WIDTH-1:0]     out_data_o,
  output logic [DATA_WIDTH/IN_WIDTH-1:0] out_lane_valid_o,
  output logic [DATA_WIDTH/8-1:0]   out_strb_o,
  output logic                      out_last_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned N_LANES    = DATA_WIDTH / IN_WIDTH;
  localparam int unsigned ELEM_BYTES = IN_WIDTH / 8;
  localparam int unsigned STRB_W     = DATA_WIDTH / 8;
  localparam int unsigned REM_W      = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Sign set, exponent all ones, mantissa zero.
  function automatic logic [IN_WIDTH-1:0] neg_inf();
    return {1'b1, {IN_EXP_BITS{1'b1}}, {(IN_WIDTH-IN_EXP_BITS-1){1'b0}}};
  endfunction

  state_e                  state_r, state_s;
  logic [31:0]             count_r;
  logic [REM_W-1:0]        rem_r;
  logic [31:0]             n_elem_s, n_beats_s;
  logic [REM_W-1:0]        rem_s;
  logic                    in_ready_s, in_hs_s, out_hs_s, start_ok_s, last_s;
  logic [DATA_WIDTH-1:0]   data_s, data_r;
  logic [N_LANES-1:0]      lane_valid_s, lane_valid_r;
  logic [STRB_W-1:0]       strb_s, strb_r;
  logic                    last_r, valid_r;

  // Vector geometry from the byte length; trailing partial element is dropped.
  always_comb begin
    n_elem_s  = tot_len_i / 32'(ELEM_BYTES);
    rem_s     = REM_W'(n_elem_s % 32'(N_LANES));
    n_beats_s = (n_elem_s / 32'(N_LANES)) + 32'(rem_s != {REM_W{1'b0}});
  end

  assign in_ready_s = (state_r == RUN) && (count_r != 32'd0) && (!valid_r || out_ready_i);
  assign in_hs_s    = in_valid_i && in_ready_s;
  assign out_hs_s   = valid_r && out_ready_i;
  assign start_ok_s = (state_r == IDLE) && start_i;
  assign last_s     = (count_r == 32'd1);

  // Lane padding of the incoming beat.
  always_comb begin
    data_s       = in_data_i;
    lane_valid_s = {N_LANES{1'b1}};
    strb_s       = {STRB_W{1'b1}};
    for (int i = 0; i < int'(N_LANES); i++) begin
      logic pad;
      pad = last_s && (rem_r != {REM_W{1'b0}}) && (32'(i) >= 32'(rem_r));
      data_s[i*IN_WIDTH +: IN_WIDTH]     = pad ? neg_inf() : in_data_i[i*IN_WIDTH +: IN_WIDTH];
      lane_valid_s[i]                    = !pad;
      strb_s[i*ELEM_BYTES +: ELEM_BYTES] = {ELEM_BYTES{!pad}};
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    if (clear_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = start_i ? ((n_beats_s != 32'd0) ? RUN : DRAIN) : IDLE;
        RUN:     state_s = (in_hs_s && last_s) ? DRAIN : RUN;
        DRAIN:   state_s = (!valid_r || out_ready_i) ? DONE : DRAIN;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Remaining-beat counter and last-beat lane count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= 32'd0;
      rem_r   <= {REM_W{1'b0}};
    end else if (clear_i) begin
      count_r <= 32'd0;
      rem_r   <= {REM_W{1'b0}};
    end else if (start_ok_s) begin
      count_r <= n_beats_s;
      rem_r   <= rem_s;
    end else if (in_hs_s) begin
      count_r <= count_r - 32'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // One-entry output register; a load wins over a simultaneous unload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_r       <= {DATA_WIDTH{1'b0}};
      lane_valid_r <= {N_LANES{1'b0}};
      strb_r       <= {STRB_W{1'b0}};
      last_r       <= 1'b0;
      valid_r      <= 1'b0;
    end else if (clear_i || (out_hs_s && !in_hs_s)) begin
      data_r       <= {DATA_WIDTH{1'b0}};
      lane_valid_r <= {N_LANES{1'b0}};
      strb_r       <= {STRB_W{1'b0}};
      last_r       <= 1'b0;
      valid_r      <= 1'b0;
    end else if (in_hs_s) begin
      data_r       <= data_s;
      lane_valid_r <= lane_valid_s;
      strb_r       <= strb_s;
      last_r       <= last_s;
      valid_r      <= 1'b1;
    end else begin
      valid_r      <= valid_r;
    end
  end

  assign in_ready_o       = in_ready_s;
  assign out_data_o       = data_r;
  assign out_lane_valid_o = lane_valid_r;
  assign out_strb_o       = strb_r;
  assign out_last_o       = last_r;
  assign out_valid_o      = valid_r;
  assign busy_o           = (state_r != IDLE);
  assign done_o           = (state_r == DONE);

endmodule

// File: tb/tb_sfm_stream_framer.sv
// Directed self-checking bench for sfm_stream_framer (FP16ALT, 128-bit words).
module tb_sfm_stream_framer;

  logic          clk = 1'b0;
  logic          rst_ni, clear_i, start_i, in_valid_i, out_ready_i;
  logic [31:0]   tot_len_i;
  logic [127:0]  in_data_i, out_data_o;
  logic          in_ready_o, out_last_o, out_valid_o, busy_o, done_o;
  logic [7:0]    out_lane_valid_o;
  logic [15:0]   out_strb_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs_cyc = -100;
  int acc_n, start_cyc, bp_n;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   lv;
    logic [15:0]  s;
    logic         l;
  } beat_t;
  beat_t q[$];
  int    dq[$];

  localparam logic [127:0] P0 = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
  localparam logic [127:0] P1 = 128'hA107_A106_A105_A104_A103_A102_A101_A100;
  localparam logic [127:0] P2 = 128'hA207_A206_A205_A204_A203_A202_A201_A200;
  localparam logic [127:0] P3 = 128'hA307_A306_A305_A304_A303_A302_A301_A300;
  localparam logic [127:0] P1_PAD = 128'hFF80_FF80_FF80_FF80_FF80_FF80_A101_A100;

  sfm_stream_framer dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .tot_len_i(tot_len_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_data_o(out_data_o), .out_lane_valid_o(out_lane_valid_o),
    .out_strb_o(out_strb_o), .out_last_o(out_last_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output-handshake and done-pulse recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      q.push_back('{out_data_o, out_lane_valid_o, out_strb_o, out_last_o});
      last_hs_cyc = cyc;
    end
    if (done_o) dq.push_back(cyc);
  end

  function automatic logic [127:0] pat(input int k);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'hA000 | (16'(k) << 8) | 16'(i);
    return r;
  endfunction

  function automatic int dq0();
    return (dq.size() > 0) ? dq[0] : -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [127:0] d,
                          input logic [7:0] lv, input logic [15:0] s, input logic l);
    if (i < q.size()) begin
      chk({tag, "_data"}, q[i].d, d);
      chk({tag, "_lane_valid"}, 128'(q[i].lv), 128'(lv));
      chk({tag, "_strb"}, 128'(q[i].s), 128'(s));
      chk({tag, "_last"}, 128'(q[i].l), 128'(l));
    end else begin
      chk({tag, "_present"}, 128'(q.size()), 128'(i + 1));
    end
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done_cnt"}, 128'(dq.size()), 128'd1);
    chk({tag, "_done_time"}, 128'(dq0()), 128'(last_hs_cyc + 1));
  endtask

  // Run one vector: offer n_offer beats, optional backpressure on a given output beat,
  // optional second start pulse while busy.
  task automatic stream(input logic [31:0] len, input int n_offer, input int bp_beat,
                        input logic [127:0] bp_data, input int restart_at);
    logic hs;
    q.delete();
    dq.delete();
    acc_n = 0;
    bp_n = 0;
    tot_len_i = len;
    start_cyc = cyc;
    for (int c = 0; c < 80; c++) begin
      start_i = (c == 0) || (c == restart_at);
      if (c == restart_at) tot_len_i = 32'd20;
      in_valid_i = (acc_n < n_offer);
      in_data_i = pat(acc_n);
      out_ready_i = 1'b1;
      if (bp_beat >= 0 && q.size() == bp_beat && out_valid_o && bp_n < 5) begin
        out_ready_i = 1'b0;
        bp_n++;
        chk("bp_hold_data", out_data_o, bp_data);
      end
      #1;
      if (!out_ready_i) chk("bp_in_ready_low", 128'(in_ready_o), 128'd0);
      hs = in_valid_i && in_ready_o;
      tick();
      if (hs) acc_n++;
      if (dq.size() != 0) break;
    end
    start_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_partial(input string tag);
    chk({tag, "_accepted"}, 128'(acc_n), 128'd2);
    chk({tag, "_nbeats"}, 128'(q.size()), 128'd2);
    chk_beat({tag, "_b0"}, 0, P0, 8'hFF, 16'hFFFF, 1'b0);
    chk_beat({tag, "_b1"}, 1, P1_PAD, 8'h03, 16'h000F, 1'b1);
    chk_done(tag);
  endtask

  task automatic abort_setup();
    tot_len_i = 32'd64;
    start_i = 1'b1;
    out_ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1;
    in_data_i = P0;
    tick();
    in_valid_i = 1'b0;
    tick();
    dq.delete();
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; tot_len_i = 32'd0;
    in_data_i = 128'd0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("rst_out_data", out_data_o, 128'd0);
    chk("rst_lane_valid", 128'(out_lane_valid_o), 128'd0);
    chk("rst_strb", 128'(out_strb_o), 128'd0);
    chk("rst_last", 128'(out_last_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_done", 128'(done_o), 128'd0);
    chk("rst_in_ready", 128'(in_ready_o), 128'd0);
    rst_ni = 1'b1;
    tick();

    // Full-beat vector, excess beats offered
    stream(32'd32, 16, -1, 128'd0, -1);
    chk("full_accepted", 128'(acc_n), 128'd2);
    chk("full_nbeats", 128'(q.size()), 128'd2);
    chk_beat("full_b0", 0, P0, 8'hFF, 16'hFFFF, 1'b0);
    chk_beat("full_b1", 1, P1, 8'hFF, 16'hFFFF, 1'b1);
    chk_done("full");

    // Partial last beat, and odd byte count
    stream(32'd20, 16, -1, 128'd0, -1);
    check_partial("len20");
    stream(32'd21, 16, -1, 128'd0, -1);
    check_partial("len21");

    // Vectors with no whole element
    stream(32'd1, 4, -1, 128'd0, -1);
    chk("len1_accepted", 128'(acc_n), 128'd0);
    chk("len1_nbeats", 128'(q.size()), 128'd0);
    chk("len1_done_time", 128'(dq0()), 128'(start_cyc + 2));
    stream(32'd0, 4, -1, 128'd0, -1);
    chk("len0_accepted", 128'(acc_n), 128'd0);
    chk("len0_nbeats", 128'(q.size()), 128'd0);
    chk("len0_done_time", 128'(dq0()), 128'(start_cyc + 2));

    // Backpressure on beat 3 of 4
    stream(32'd64, 16, 2, P2, -1);
    chk("bp_cycles", 128'(bp_n), 128'd5);
    chk("bp_accepted", 128'(acc_n), 128'd4);
    chk("bp_nbeats", 128'(q.size()), 128'd4);
    chk_beat("bp_b0", 0, P0, 8'hFF, 16'hFFFF, 1'b0);
    chk_beat("bp_b1", 1, P1, 8'hFF, 16'hFFFF, 1'b0);
    chk_beat("bp_b2", 2, P2, 8'hFF, 16'hFFFF, 1'b0);
    chk_beat("bp_b3", 3, P3, 8'hFF, 16'hFFFF, 1'b1);
    chk_done("bp");

    // Start while busy is ignored
    stream(32'd64, 16, -1, 128'd0, 2);
    chk("rs_accepted", 128'(acc_n), 128'd4);
    chk("rs_nbeats", 128'(q.size()), 128'd4);
    chk_beat("rs_b3", 3, P3, 8'hFF, 16'hFFFF, 1'b1);
    chk_done("rs");

    // Synchronous clear with a held beat
    abort_setup();
    chk("clr_pre_valid", 128'(out_valid_o), 128'd1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_busy", 128'(busy_o), 128'd0);
    chk("clr_out_valid", 128'(out_valid_o), 128'd0);
    chk("clr_out_data", out_data_o, 128'd0);
    out_ready_i = 1'b1;
    tick();
    tick();
    tick();
    chk("clr_no_done", 128'(dq.size()), 128'd0);

    // Asynchronous reset mid-beat
    abort_setup();
    #3;
    rst_ni = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid_o), 128'd0);
    chk("arst_busy", 128'(busy_o), 128'd0);
    chk("arst_lane_valid", 128'(out_lane_valid_o), 128'd0);
    #1;
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    tick();
    tick();
    tick();
    chk("arst_no_done", 128'(dq.size()), 128'd0);

    // Normal single-beat vector after abort
    stream(32'd16, 4, -1, 128'd0, -1);
    chk("post_accepted", 128'(acc_n), 128'd1);
    chk("post_nbeats", 128'(q.size()), 128'd1);
    chk_beat("post_b0", 0, P0, 8'hFF, 16'hFFFF, 1'b1);
    chk_done("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfm_stream_framer.md
# sfm_stream_framer

Stream framing stage between the input HCI streamer and the softmax datapath. It counts beats of a vector whose length is given in bytes and tags the final beat. On a partial last beat it replaces unused lanes with negative infinity, so max search and exponentiation ignore them. It also produces per-lane valid flags and a byte strobe for the datapath and the output streamer. The controller starts it alongside each input stream, and it signals completion once the last beat has left its output register.

## Interface
- DATA_WIDTH, 128, stream word width in bits.
- IN_FPFORMAT, fpnew_pkg::FP16ALT, element format; IN_WIDTH = fp_width(IN_FPFORMAT); N_LANES = DATA_WIDTH / IN_WIDTH.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- clear_i  in  1  synchronous clear; returns to IDLE and drops any held beat.
- start_i  in  1  start pulse; sampled only in IDLE.
- tot_len_i  in  32  vector length in bytes; sampled on accepted start.
- in_data_i  in  DATA_WIDTH  upstream beat; lane i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- in_valid_i  in  1  upstream valid.
- in_ready_o  out  1  upstream ready.
- out_data_o  out  DATA_WIDTH  framed beat, with padded lanes.
- out_lane_valid_o  out  N_LANES  one bit per lane carrying a real element.
- out_strb_o  out  DATA_WIDTH/8  byte strobe; every byte of a valid lane is set.
- out_last_o  out  1  marks the final beat.
- out_valid_o  out  1  downstream valid.
- out_ready_i  in  1  downstream ready.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.

## Operation
- Element count: n_elem = tot_len_i / (IN_WIDTH/8), truncating. Trailing bytes that do not form a whole element are ignored.
- Beat count: n_beats = ceil(n_elem / N_LANES).
- Last-beat lanes: rem = n_elem mod N_LANES; rem = 0 means the last beat is full.
- Registers:
  - a 32-bit remaining-beat counter, loaded with n_beats on start;
  - rem;
  - a one-entry output register holding data, lane_valid, strb, last and valid.
- Beat processing:
  - Non-last beats pass through unchanged, with lane_valid all ones and strb all ones.
  - Last beat with rem ≠ 0: lanes i ≥ rem are replaced by -inf (sign 1, exponent all ones, mantissa 0; 16'hFF80 for FP16ALT), and their lane_valid and strb bits are 0.
- States:
  - IDLE: busy_o = 0, in_ready_o = 0. On start_i, go to RUN if n_beats ≠ 0, otherwise go to DRAIN.
  - RUN: in_ready_o = (count ≠ 0) & (~out_valid_o | out_ready_i). Each input handshake decrements count and loads the output register. When the handshake takes count from 1 to 0, go to DRAIN.
  - DRAIN: in_ready_o = 0. Wait until the output register is empty or is being emptied (out_valid_o = 0, or out_valid_o & out_ready_i), then go to DONE.
  - DONE: done_o = 1 for one cycle, then IDLE.
- The output register loads on an input handshake. It clears on an output handshake that has no simultaneous load. A simultaneous load and unload gives full throughput.
- Excess upstream beats after the last beat are not accepted: in_ready_o stays 0 until the next start.
- start_i outside IDLE is ignored.
- clear_i has priority over all other events, and state returns to IDLE in the next cycle. The count, the output register and out_valid_o are zeroed, and no done_o pulse is produced.
- An asserted rst_ni at any time gives the reset values immediately.

## Timing
- Reset and clear values: all outputs are 0 and the state is IDLE.
- Latency: one cycle from the input handshake to out_valid_o. Throughput: one beat per cycle when out_ready_i is high.
- out_data_o, out_lane_valid_o, out_strb_o and out_last_o stay stable while out_valid_o = 1 and out_ready_i = 0.
- in_ready_o is combinational from out_ready_i and registered state only, with no path from in_valid_i.
- done_o rises in the cycle after the last output handshake. For n_beats = 0 it rises two cycles after the start cycle (IDLE→DRAIN→DONE).
- A new start_i is accepted in the IDLE cycle immediately after DONE.

## Test plan
- Full-beat vector: FP16ALT, 128-bit words, tot_len = 32, sixteen input beats offered back-to-back.
  - Exactly two output beats, each with lane_valid = 8'hFF and strb = 16'hFFFF.
  - out_last_o is set on beat 2 only.
  - Extra input beats are left unaccepted.
  - done_o pulses once.
- Partial last beat: tot_len = 20 (10 elements).
  - Beat 2 has lane_valid = 8'h03, strb = 16'h000F, out_last_o = 1.
  - Lanes 2–7 of beat 2 read 16'hFF80; lanes 0–1 are unchanged.
- Odd byte count and empty vector:
  - tot_len = 21 behaves identically to tot_len = 20.
  - tot_len = 1 and tot_len = 0 produce no out_valid_o, with done_o two cycles after start_i.
- Backpressure: out_ready_i held low for 5 cycles during beat 3 of a 4-beat vector.
  - Beat 3 is held stable and in_ready_o stays low.
  - No beat is lost or duplicated; the output order matches the input order.
- Mid-operation abort:
  - clear_i during RUN with a beat held gives IDLE the next cycle, out_valid_o = 0, and no done_o.
  - The same check applies for rst_ni asserted asynchronously mid-beat.
  - A subsequent start with tot_len = 16 completes normally in one full beat.
- Start while busy: a start_i pulse in RUN with a different tot_len_i is ignored, and the original beat count completes.
